// File: rtl/bus_arb_pkg.sv
// Shared definitions for the round-robin bus arbiter:
// FSM state encoding and release-cause codes.
package bus_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    REL_NONE    = 2'd0,
    REL_LAST    = 2'd1,
    REL_MAX     = 2'd2,
    REL_ABANDON = 2'd3
  } rel_e;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first set req bit at or after ptr,
// wrapping modulo NREQ. Ports: req, ptr in; found, idx out.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic                    found,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int OW = $clog2(NREQ);
  localparam logic [OW:0] N_W = (OW+1)'(NREQ);

  logic [NREQ-1:0] rot;
  logic [OW:0]     sum;

  // rot[k] is req[(ptr + k) mod NREQ]
  assign rot = NREQ'({req, req} >> ptr);

  // Descending scan: the lowest hit is written last and wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k[OW-1:0]]) begin
        sum = {1'b0, ptr} + {1'b0, k[OW-1:0]};
        if (sum >= N_W)
          sum = sum - N_W;
        found = 1'b1;
        idx   = sum[OW-1:0];
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one bus among NREQ requesters.
// Ports: clk, rst, req/last/data in; gnt, owner, bus_* , preempt.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         last,
  input  logic [NREQ*WIDTH-1:0]   data,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic [WIDTH-1:0]        bus_data,
  output logic                    bus_valid,
  output logic                    bus_last,
  input  logic                    bus_ready,
  output logic                    preempt
);

  localparam int OW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BEATS);
  localparam logic [OW-1:0] TOP = OW'(NREQ - 1);
  localparam logic [CW-1:0] CNT_END = CW'(MAX_BEATS - 1);

  state_e          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   rr_q, rr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            pre_q;
  rel_e            rel;

  logic            found;
  logic [OW-1:0]   pick;
  logic [WIDTH-1:0] beat [NREQ];
  logic            busy;
  logic            accept;

  for (genvar i = 0; i < NREQ; i++) begin : g_split
    assign beat[i] = data[i*WIDTH +: WIDTH];
  end

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req   (req),
    .ptr   (rr_q),
    .found (found),
    .idx   (pick)
  );

  assign busy      = (state_q == BUSY);
  assign bus_valid = busy & req[owner_q];
  assign bus_last  = busy & last[owner_q];
  assign bus_data  = busy ? beat[owner_q] : '0;
  assign accept    = bus_valid & bus_ready;

  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign preempt = pre_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    rel     = REL_NONE;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          owner_d = pick;
          gnt_d   = NREQ'(1) << pick;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        // last beats the beat limit on the same beat
        if (!req[owner_q])
          rel = REL_ABANDON;
        else if (accept) begin
          if (last[owner_q])
            rel = REL_LAST;
          else if (cnt_q == CNT_END)
            rel = REL_MAX;
          else
            cnt_d = cnt_q + CW'(1);
        end
        if (rel != REL_NONE) begin
          state_d = IDLE;
          owner_d = '0;
          gnt_d   = '0;
          cnt_d   = '0;
          rr_d    = (owner_q == TOP) ? '0
                  : owner_q + OW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      pre_q   <= (rel == REL_MAX);
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: transaction-level model plus
// directed scenarios with literal expectations.
module tb_bus_arbiter;
  import bus_arb_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] last = '0;
  logic [N*W-1:0] data = '0;
  logic         bus_ready = 1'b1;
  logic [N-1:0] gnt;
  logic [1:0]   owner;
  logic [W-1:0] bus_data;
  logic         bus_valid, bus_last, preempt;

  bus_arbiter #(
    .NREQ      (N),
    .WIDTH     (W),
    .MAX_BEATS (MB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .last      (last),
    .data      (data),
    .gnt       (gnt),
    .owner     (owner),
    .bus_data  (bus_data),
    .bus_valid (bus_valid),
    .bus_last  (bus_last),
    .bus_ready (bus_ready),
    .preempt   (preempt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // requester behaviour
  bit act [N];
  int len [N];
  int bi  [N];
  int ntx [N];

  // model state
  bit   m_busy = 0;
  bit   m_pre  = 0;
  int   m_owner = 0;
  int   m_rr = 0;
  int   m_beats = 0;
  int   acc_i = -1;
  bit   acc_last = 0;
  rel_e rel_q [$];

  // observation logs
  int   glog [$];
  int   gcyc [$];
  int   acc_cnt [N];
  int   pre_cnt = 0;
  int   cyc = 0;
  bit   chk_en = 0;
  logic [N-1:0] prev_gnt = '0;
  logic [N-1:0] e_gnt;
  int   order [5];

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t",
               nm, got, want, $time);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s timed out t=%0t", nm, $time);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req[i]  = act[i];
      last[i] = act[i] && len[i] != 0
             && bi[i] == len[i] - 1;
      data[i*W +: W] = W'(i * 64 + bi[i]);
    end
  endtask

  task automatic release_m(input rel_e c);
    m_rr   = (m_owner + 1) % N;
    m_busy = 0;
    rel_q.push_back(c);
  endtask

  task automatic model_edge();
    int c;
    acc_i    = -1;
    acc_last = 0;
    if (rst) begin
      m_busy = 0; m_owner = 0; m_rr = 0;
      m_pre = 0; m_beats = 0;
      return;
    end
    m_pre = 0;
    if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        c = (m_rr + k) % N;
        if (req[c]) begin
          m_busy = 1; m_owner = c; m_beats = 0;
          break;
        end
      end
    end else if (!req[m_owner]) begin
      release_m(REL_ABANDON);
    end else if (bus_ready) begin
      acc_i    = m_owner;
      acc_last = last[m_owner];
      m_beats++;
      if (acc_last)
        release_m(REL_LAST);
      else if (m_beats == MB) begin
        release_m(REL_MAX);
        m_pre = 1;
      end
    end
  endtask

  task automatic step();
    drive();
    @(posedge clk);
    model_edge();
    #1;
    if (acc_i >= 0) begin
      if (acc_last) begin
        bi[acc_i]  = 0;
        ntx[acc_i] = ntx[acc_i] - 1;
        act[acc_i] = ntx[acc_i] > 0;
      end else
        bi[acc_i]++;
    end
    drive();
  endtask

  function automatic bit any_act();
    for (int i = 0; i < N; i++)
      if (act[i]) return 1;
    return 0;
  endfunction

  task automatic wait_quiet(input int max);
    bit ok = 0;
    for (int k = 0; k < max; k++) begin
      step();
      if (!m_busy && !any_act()) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout("wait_quiet");
  endtask

  task automatic wait_log(input int n, input int max);
    bit ok = 0;
    for (int k = 0; k < max; k++) begin
      step();
      if (glog.size() >= n) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout("wait_log");
  endtask

  task automatic clear();
    for (int i = 0; i < N; i++) acc_cnt[i] = 0;
    glog.delete();
    gcyc.delete();
    rel_q.delete();
    pre_cnt = 0;
  endtask

  function automatic int glog_at(input int k);
    return (glog.size() > k) ? glog[k] : -1;
  endfunction

  // per-cycle compare against the model
  initial forever begin
    @(negedge clk);
    cyc++;
    if (chk_en) begin
      e_gnt = m_busy ? (N'(1) << m_owner) : '0;
      chk("gnt", gnt, e_gnt);
      chk("owner", owner, m_busy ? m_owner : 0);
      chk("bus_valid", bus_valid,
          m_busy && req[m_owner]);
      chk("bus_last", bus_last,
          m_busy && last[m_owner]);
      chk("bus_data", bus_data,
          m_busy ? data[m_owner*W +: W] : 0);
      chk("preempt", preempt, m_pre);
      if (bus_valid && bus_ready && !rst)
        acc_cnt[owner]++;
      if (preempt) pre_cnt++;
      if (gnt != 0 && prev_gnt == 0) begin
        glog.push_back(owner);
        gcyc.push_back(cyc);
      end
      prev_gnt = gnt;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      act[i] = 0; len[i] = 0;
      bi[i] = 0; ntx[i] = 0; acc_cnt[i] = 0;
    end
    bus_ready = 1;
    rst = 1;
    step();
    step();
    chk("rst_gnt", gnt, 0);
    chk("rst_owner", owner, 0);
    chk("rst_valid", bus_valid, 0);
    chk("rst_data", bus_data, 0);
    chk("rst_pre", preempt, 0);
    rst = 0;
    chk_en = 1;

    // single requester, 3 beats
    clear();
    act[2] = 1; len[2] = 3; ntx[2] = 1;
    step();
    chk("s1_gnt", gnt, 4'b0100);
    wait_quiet(40);
    chk("s1_beats", acc_cnt[2], 3);
    chk("s1_rr", m_rr, 3);
    chk("s1_gnt_end", gnt, 0);

    // all four, 2-beat transfers
    rst = 1;
    step();
    rst = 0;
    clear();
    for (int i = 0; i < N; i++) begin
      act[i] = 1; len[i] = 2; ntx[i] = 1;
    end
    ntx[0] = 2;
    wait_quiet(60);
    order = '{0, 1, 2, 3, 0};
    chk("s2_ngrants", glog.size(), 5);
    for (int k = 0; k < 5; k++)
      chk("s2_order", glog_at(k), order[k]);
    for (int k = 0; k < 4; k++)
      if (gcyc.size() > k + 1)
        chk("s2_gap", gcyc[k+1] - gcyc[k], 3);

    // requester 1 never sends last
    clear();
    act[1] = 1; len[1] = 0;
    step(); step(); step();
    act[2] = 1; len[2] = 1; ntx[2] = 1;
    act[0] = 1; len[0] = 1; ntx[0] = 1;
    wait_log(3, 60);
    act[1] = 0;
    wait_quiet(40);
    chk("s3_g0", glog_at(0), 1);
    chk("s3_g1", glog_at(1), 2);
    chk("s3_g2", glog_at(2), 0);
    chk("s3_beats", acc_cnt[1], 16);
    chk("s3_pre", pre_cnt, 1);
    chk("s3_rel", rel_q.size() > 0 ? rel_q[0] : REL_NONE,
        REL_MAX);

    // ready stall mid-transfer
    clear();
    act[3] = 1; len[3] = 6; ntx[3] = 1;
    wait_log(1, 10);
    step();
    bus_ready = 0;
    repeat (5) step();
    chk("s4_frozen", acc_cnt[3], 2);
    chk("s4_gnt", gnt, 4'b1000);
    chk("s4_data", bus_data, 194);
    bus_ready = 1;
    wait_quiet(20);
    chk("s4_beats", acc_cnt[3], 6);
    chk("s4_rel", rel_q.size() > 0 ? rel_q[0] : REL_NONE,
        REL_LAST);

    // owner 3 abandons with requester 0 pending
    clear();
    act[3] = 1; len[3] = 10; ntx[3] = 1;
    wait_log(1, 10);
    act[0] = 1; len[0] = 1; ntx[0] = 1;
    step(); step();
    act[3] = 0;
    step();
    chk("s5_gnt_off", gnt, 0);
    chk("s5_rr", m_rr, 0);
    chk("s5_pre", preempt, 0);
    step();
    chk("s5_gnt0", gnt, 4'b0001);
    wait_quiet(10);
    chk("s5_g0", glog_at(0), 3);
    chk("s5_g1", glog_at(1), 0);
    chk("s5_pre_cnt", pre_cnt, 0);
    chk("s5_rel", rel_q.size() > 0 ? rel_q[0] : REL_NONE,
        REL_ABANDON);

    // reset while busy on beat 7
    clear();
    act[2] = 1; len[2] = 0;
    begin
      bit ok = 0;
      for (int k = 0; k < 30; k++) begin
        step();
        if (acc_cnt[2] >= 6) begin
          ok = 1;
          break;
        end
      end
      if (!ok) timeout("s6_beats");
    end
    chk("s6_busy", gnt, 4'b0100);
    rst = 1;
    step();
    chk("s6_gnt", gnt, 0);
    chk("s6_owner", owner, 0);
    chk("s6_valid", bus_valid, 0);
    chk("s6_pre", preempt, 0);
    chk("s6_rr", m_rr, 0);
    rst = 0;
    step();
    chk("s6_regnt", gnt, 4'b0100);
    act[2] = 0;
    wait_quiet(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter that shares one WIDTH-bit bus among NREQ requesters. It sequences multi-beat transfers with a valid/ready handshake toward a single sink. Each grant is bounded by MAX_BEATS so that no requester can starve the others. It sits between the requesting blocks (e.g. dff-based register stages) and the shared `bus`, and drives the sink side of that bus.

## Interface

Parameters:
- NREQ, 4: number of requesters (2..8).
- WIDTH, 8: bus data width.
- MAX_BEATS, 16: maximum accepted beats per grant (2..256).

Ports:
- clk  input  1  system clock; all state changes on posedge clk.
- rst  input  1  reset, synchronous, active-high.
- req  input  NREQ  req[i] high while requester i has data; held for the whole transfer.
- last  input  NREQ  last[i] marks requester i's current beat as its final beat.
- data  input  NREQ*WIDTH  requester i's beat on data[i*WIDTH +: WIDTH].
- gnt  output  NREQ  one-hot grant, registered; all-zero when idle.
- owner  output  $clog2(NREQ)  index of the granted requester; 0 when idle.
- bus_data  output  WIDTH  data of the owner; 0 when idle.
- bus_valid  output  1  req[owner] & busy.
- bus_last  output  1  last[owner] & busy.
- bus_ready  input  1  sink accepts the beat when bus_valid & bus_ready.
- preempt  output  1  one-cycle pulse, registered; grant was force-released at MAX_BEATS.

## Operation

- States:
  - IDLE: gnt = 0, bus_valid = 0. If any req is high, pick the first i with req[i] = 1, searching rr_ptr, rr_ptr+1, …, wrapping modulo NREQ. Load owner and gnt, clear beat_cnt, go to BUSY.
  - BUSY: the bus mirrors the owner's inputs combinationally through a mux on the registered owner. A beat is accepted when bus_valid & bus_ready, and each accepted beat increments beat_cnt.
- Release from BUSY to IDLE happens on the first of these conditions:
  - (a) the accepted beat has bus_last = 1: normal end.
  - (b) the accepted beat is beat number MAX_BEATS (beat_cnt == MAX_BEATS-1) without last: forced release, preempt = 1 for the next cycle.
  - (c) req[owner] = 0 while BUSY: abandon, no beat accepted.
- On any release, rr_ptr ← owner+1. When owner = NREQ-1, rr_ptr wraps to 0.
- Simultaneous conditions:
  - If (a) and (b) hit on the same beat, (a) wins and preempt stays 0.
  - A new req arriving in the release cycle is only considered in the following IDLE cycle.
- Requests from non-owners are ignored while BUSY. Their data and last inputs have no effect.
- Reset values: state IDLE, rr_ptr 0, beat_cnt 0, gnt 0, owner 0, preempt 0. All combinational bus outputs therefore read 0.
- If rst is asserted mid-transfer, the grant drops after that edge and no bus_last is emitted. The requester must re-request after reset.
- Width rules:
  - beat_cnt is $clog2(MAX_BEATS) bits and never exceeds MAX_BEATS-1.
  - owner and rr_ptr are $clog2(NREQ) bits and are compared modulo NREQ.

## Timing

- Request to grant: req seen high in an IDLE cycle produces gnt high after the next edge, a latency of 1 cycle.
- First beat: the first beat can be accepted in the first BUSY cycle.
- Handoff gap: gnt is 0 for exactly one cycle between consecutive grants (the IDLE arbitration cycle). Maximum bus utilisation is therefore MAX_BEATS/(MAX_BEATS+1).
- Release timing: the release edge is the edge that accepts the final beat (or sees req[owner] low). gnt, owner and state change after that edge.
- preempt is high for exactly the cycle following a forced release.
- Worst-case wait for a continuously requesting i is (NREQ-1)·(MAX_BEATS+1) cycles plus 1.

## Structure

- Shared package `bus_arb_pkg`: state encoding (IDLE = 0, BUSY = 1) and the release-cause constants (REL_LAST, REL_MAX, REL_ABANDON), reused by the bench's scoreboard.
- One sub-module `rr_pick`: a combinational rotate-priority-encode taking req and rr_ptr and returning a found flag plus an index. It is parameterised by NREQ and is reusable by other shared-resource controllers.
- All registers live in `bus_arbiter`.

## Test plan

- Reset, then single requester: req = 4'b0100 with 3 beats (last on the third), bus_ready = 1 → gnt = 4'b0100 one cycle later, 3 accepted beats, bus_last on beat 3, gnt = 0 next cycle, rr_ptr = 3.
- All four requesting continuously, each sending 2-beat transfers → grant order 0,1,2,3,0 with exactly one idle cycle between grants.
- MAX_BEATS = 16, requester 1 never asserts last → release after the 16th accepted beat, preempt pulses for one cycle, next grant goes to 2 if requesting, else 3, 0, then 1.
- bus_ready held low for 5 cycles mid-transfer → beat_cnt frozen, bus_data stable, no release; transfer completes after ready returns.
- Owner 3 drops req mid-transfer with req[0] pending → gnt = 0 next cycle, rr_ptr wraps to 0, requester 0 granted on the following edge, preempt stays 0.
- rst asserted while BUSY on beat 7 → gnt, owner, bus_valid and preempt all 0 after that edge; rr_ptr = 0; the arbiter restarts from IDLE.
